// File: rtl/alu_8bit.sv
// Registered ALU: add/sub/logic/shift on two unsigned WIDTH-bit operands.
// Optional build macro ALU_SATURATE_EN clamps ADD/SUB results instead of wrapping.
module alu_8bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             carry,
    output logic             valid
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             cout;

    // diff[WIDTH] is the borrow of the extended subtraction
    always_comb begin
        sum  = {1'b0, A} + {1'b0, B};
        diff = {1'b0, A} - {1'b0, B};
        res  = '0;
        cout = 1'b0;
        unique case (sel)
            OP_ADD: begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
`ifdef ALU_SATURATE_EN
                if (sum[WIDTH]) res = '1;
`endif
            end
            OP_SUB: begin
                res  = diff[WIDTH-1:0];
                cout = diff[WIDTH];
`ifdef ALU_SATURATE_EN
                if (diff[WIDTH]) res = '0;
`endif
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_NOT: res = ~A;
            OP_SHL: begin
                res  = {A[WIDTH-2:0], 1'b0};
                cout = A[WIDTH-1];
            end
            OP_SHR: begin
                res  = {1'b0, A[WIDTH-1:1]};
                cout = A[0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y     <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                Y     <= res;
                carry <= cout;
                zero  <= (res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit (WIDTH=4) with an expected-result queue.
// Honours ALU_SATURATE_EN to match the saturating build.
module tb_alu_8bit;

    localparam int W = 4;
`ifdef ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   sel = '0;
    logic [W-1:0] Y;
    logic         zero;
    logic         carry;
    logic         valid;

    int checks = 0;
    int failures = 0;

    // {y, carry, zero}
    typedef logic [W+1:0] exp_t;
    exp_t sbq[$];
    exp_t held;

    alu_8bit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .A(A), .B(B), .sel(sel),
        .Y(Y), .zero(zero), .carry(carry), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int a, int b, int s);
        int r;
        int c;
        r = 0;
        c = 0;
        case (s)
            0: begin
                r = a + b;
                c = (r >= 16) ? 1 : 0;
                r = r % 16;
                if (SAT && c == 1) r = 15;
            end
            1: begin
                c = (a < b) ? 1 : 0;
                r = (a - b + 16) % 16;
                if (SAT && c == 1) r = 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin
                c = a / 8;
                r = (a * 2) % 16;
            end
            default: begin
                c = a % 2;
                r = a / 2;
            end
        endcase
        return {r[W-1:0], c[0], (r == 0)};
    endfunction

    // Drives one capture and queues the bench's own expectation.
    task automatic drive(input int a, input int b, input int s,
                         input int ey, input int ec);
        int yy;
        @(negedge clk);
        A   = a[W-1:0];
        B   = b[W-1:0];
        sel = s[2:0];
        en  = 1'b1;
        yy  = ey;
        sbq.push_back({yy[W-1:0], ec[0], (ey == 0)});
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2;
        checks++;
        if ({Y, carry, zero, valid} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_initial got Y=%b c=%b z=%b v=%b want 0000 0 1 0",
                     Y, carry, zero, valid);
        end
        rst = 1'b0;
        drive(5, 3, 0, 8, 0);
        @(posedge clk);
        #1;
        void'(sbq.pop_front());
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({Y, carry, zero, valid} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_async got Y=%b c=%b z=%b v=%b want 0000 0 1 0",
                     Y, carry, zero, valid);
        end
        A = 4'hF; B = 4'h1; sel = 3'b000; en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({Y, carry, zero, valid} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_override got Y=%b c=%b z=%b v=%b want 0000 0 1 0",
                     Y, carry, zero, valid);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic test_add;
        int v[2][5] = '{'{5, 3, 0, 8, 0},
                        '{15, 1, 0, SAT ? 15 : 0, 1}};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({Y, carry, zero, valid} !== {e, 1'b1}) begin
                failures++;
                $display("FAIL add_%0d got Y=%b c=%b z=%b v=%b want Y=%b c=%b z=%b v=1",
                         i, Y, carry, zero, valid, e[W+1:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_sub;
        int v[4][5] = '{'{5, 3, 1, 2, 0},
                        '{3, 5, 1, SAT ? 0 : 14, 1},
                        '{0, 1, 1, SAT ? 0 : 15, 1},
                        '{7, 7, 1, 0, 0}};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({Y, carry, zero, valid} !== {e, 1'b1}) begin
                failures++;
                $display("FAIL sub_%0d got Y=%b c=%b z=%b v=%b want Y=%b c=%b z=%b v=1",
                         i, Y, carry, zero, valid, e[W+1:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_logic;
        int v[6][5] = '{'{5, 3, 2, 1, 0},
                        '{5, 3, 3, 7, 0},
                        '{5, 3, 4, 6, 0},
                        '{5, 3, 5, 10, 0},
                        '{5, 12, 5, 10, 0},
                        '{5, 10, 2, 0, 0}};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({Y, carry, zero, valid} !== {e, 1'b1}) begin
                failures++;
                $display("FAIL logic_%0d got Y=%b c=%b z=%b v=%b want Y=%b c=%b z=%b v=1",
                         i, Y, carry, zero, valid, e[W+1:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_shift;
        int v[4][5] = '{'{9, 0, 6, 2, 1},
                        '{9, 0, 7, 4, 1},
                        '{6, 15, 6, 12, 0},
                        '{6, 15, 7, 3, 0}};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({Y, carry, zero, valid} !== {e, 1'b1}) begin
                failures++;
                $display("FAIL shift_%0d got Y=%b c=%b z=%b v=%b want Y=%b c=%b z=%b v=1",
                         i, Y, carry, zero, valid, e[W+1:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_hold;
        exp_t e;
        drive(5, 3, 0, 8, 0);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checks++;
        if ({Y, carry, zero, valid} !== {e, 1'b1}) begin
            failures++;
            $display("FAIL hold_capture got Y=%b c=%b z=%b v=%b want Y=%b c=%b z=%b v=1",
                     Y, carry, zero, valid, e[W+1:2], e[1], e[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en  = 1'b0;
            A   = 4'(i + 10);
            B   = 4'(i + 6);
            sel = 3'(i + 1);
            @(posedge clk);
            #1;
            checks++;
            if ({Y, carry, zero, valid} !== {e, 1'b0}) begin
                failures++;
                $display("FAIL hold_%0d got Y=%b c=%b z=%b v=%b want Y=%b c=%b z=%b v=0",
                         i, Y, carry, zero, valid, e[W+1:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int a, b, s;
        bit e;
        exp_t x;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            s = $urandom_range(0, 7);
            e = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            A = a[W-1:0];
            B = b[W-1:0];
            sel = s[2:0];
            en = e;
            if (e) sbq.push_back(model(a, b, s));
            @(posedge clk);
            #1;
            if (e) held = sbq.pop_front();
            checks++;
            if ({Y, carry, zero, valid} !== {held, e}) begin
                failures++;
                $display("FAIL b2b_%0d sel=%0d a=%0d b=%0d got Y=%b c=%b z=%b v=%b want Y=%b c=%b z=%b v=%b",
                         i, s, a, b, Y, carry, zero, valid,
                         held[W+1:2], held[1], held[0], e);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d left want 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
